glyph_loader: RTL and testbench

Write-side companion to the VGA character path: accepts a row-by-row stream of 16-pixel glyph rows from the SoC peripheral bus and assembles a 16x16 glyph. It then commits the glyph as a single 256-bit write into the character glyph memory, the same store the pixel renderer reads. The bit packing it produces is exactly the packing the renderer decodes, so a loaded glyph displays unmodified.

---
 rtl/glyph_loader_pkg.sv | 24 ++
 rtl/glyph_loader_if.sv | 13 +
 rtl/glyph_loader.sv | 123 ++++++++++++
 tb/tb_glyph_loader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_loader_pkg.sv
// Shared VGA character-path definitions: glyph geometry, slot index width,
// loader FSM states and the row-to-bit-slice placement helper.
package glyph_loader_pkg;

    localparam int CHAR_W     = 16;
    localparam int CHAR_H     = 16;
    localparam int SEL_W      = 4;
    localparam int GLYPH_BITS = 256;
    localparam int ROW_W      = 4;

    localparam logic [ROW_W-1:0] LAST_ROW = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    // Row r occupies bits [255-16r -: 16], matching the renderer's decode.
    function automatic logic [7:0] row_msb(input logic [ROW_W-1:0] row);
        return 8'd255 - {row, 4'b0000};
    endfunction

endpackage

// File: rtl/glyph_loader_if.sv
// Row-beat stream from the peripheral bus into the glyph loader.
interface glyph_loader_if;
    import glyph_loader_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [SEL_W-1:0] s_sel;
    logic [CHAR_W-1:0] s_row;

    modport master (output s_valid, output s_sel, output s_row, input s_ready);
    modport slave  (input s_valid, input s_sel, input s_row, output s_ready);

endinterface

// File: rtl/glyph_loader.sv
// Assembles sixteen 16-pixel rows into one glyph and commits it to glyph
// memory as a single 256-bit write.
module glyph_loader
    import glyph_loader_pkg::*;
(
    input  logic                  vga_clk,
    input  logic                  rst_n,
    glyph_loader_if.slave         s,
    output logic                  wr_en,
    output logic [SEL_W-1:0]      wr_addr,
    output logic [GLYPH_BITS-1:0] wr_data,
    output logic                  busy,
    output logic                  err
);

    state_e                  state_q, state_d;
    logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [GLYPH_BITS-1:0]   glyph_q, glyph_d;
    logic                    wr_en_q, wr_en_d;
    logic [SEL_W-1:0]        wr_addr_q, wr_addr_d;
    logic [GLYPH_BITS-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    alive_q;
    logic                    accept_s;
    logic [7:0]              row_msb_s;

    // Ready stays low through reset and the first edge after release.
    assign s.s_ready = alive_q & (state_q != ST_COMMIT);
    assign accept_s  = s.s_valid & s.s_ready;
    assign row_msb_s = row_msb(row_cnt_q);

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign err     = err_q;

    // Next-state, assembly buffer and registered-output decode.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        sel_d     = sel_q;
        glyph_d   = glyph_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sel_d                          = s.s_sel;
                    glyph_d[GLYPH_BITS-1 -: CHAR_W] = s.s_row;
                    row_cnt_d                      = 4'd1;
                    state_d                        = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    if (s.s_sel != sel_q) begin
                        // Slot changed mid-glyph: drop the partial, restart at row 0.
                        err_d                          = 1'b1;
                        sel_d                          = s.s_sel;
                        glyph_d[GLYPH_BITS-1 -: CHAR_W] = s.s_row;
                        row_cnt_d                      = 4'd1;
                    end else begin
                        glyph_d[row_msb_s -: CHAR_W] = s.s_row;
                        if (row_cnt_q == LAST_ROW) begin
                            row_cnt_d = 4'd0;
                            state_d   = ST_COMMIT;
                            wr_en_d   = 1'b1;
                            wr_addr_d = sel_q;
                            wr_data_d = glyph_d;
                        end else begin
                            row_cnt_d = row_cnt_q + 4'd1;
                        end
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                row_cnt_d = 4'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= 4'd0;
            sel_q     <= 4'd0;
            glyph_q   <= 256'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 4'd0;
            wr_data_q <= 256'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            alive_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            sel_q     <= sel_d;
            glyph_q   <= glyph_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            alive_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glyph_loader.sv
// Randomized and directed bench for glyph_loader against a glyph-level model.
module tb_glyph_loader;
    import glyph_loader_pkg::*;

    logic         vga_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [255:0] wr_data;
    logic         busy;
    logic         err;

    always #5 vga_clk = ~vga_clk;

    glyph_loader_if sif();

    glyph_loader dut (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .s       (sif),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .err     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Glyph-level model: a list of rows for the current slot, packed by the pixel rule.
    bit           m_commit;
    bit           m_acc;
    int           m_cnt;
    logic [3:0]   m_sel;
    logic [15:0]  m_rows [16];
    logic         exp_ready, exp_wr_en, exp_busy, exp_err;
    logic [3:0]   exp_wr_addr;
    logic [255:0] exp_wr_data;

    function automatic logic [255:0] pack_rows();
        logic [255:0] d;
        d = 256'd0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                d[255 - (16*r + c)] = m_rows[r][15 - c];
        return d;
    endfunction

    task automatic model_reset();
        m_commit = 1'b0; m_acc = 1'b0; m_cnt = 0; m_sel = 4'd0;
        exp_ready = 1'b0; exp_wr_en = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
        exp_wr_addr = 4'd0; exp_wr_data = 256'd0;
    endtask

    task automatic model_step();
        m_acc     = sif.s_valid && exp_ready;
        exp_wr_en = 1'b0;
        exp_err   = 1'b0;
        if (m_commit) begin
            m_commit = 1'b0;
        end else if (m_acc) begin
            if (m_cnt > 0 && sif.s_sel != m_sel) begin
                exp_err = 1'b1;
                m_cnt   = 0;
            end
            if (m_cnt == 0) m_sel = sif.s_sel;
            m_rows[m_cnt] = sif.s_row;
            m_cnt++;
            if (m_cnt == 16) begin
                exp_wr_en   = 1'b1;
                exp_wr_addr = m_sel;
                exp_wr_data = pack_rows();
                m_cnt       = 0;
                m_commit    = 1'b1;
            end
        end
        exp_busy  = m_commit || (m_cnt > 0);
        exp_ready = !m_commit;
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge vga_clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison plus a record of every write seen at the memory port.
    int           cyc = 0;
    int           wr_count [16];
    int           wr_total = 0;
    int           err_count = 0;
    int           wr_cyc_prev = 0;
    int           wr_cyc_last = 0;
    logic [3:0]   last_addr = 4'd0;
    logic [255:0] last_data = 256'd0;

    initial begin : compare
        for (int i = 0; i < 16; i++) wr_count[i] = 0;
        forever begin
            @(negedge vga_clk);
            cyc++;
            check("s_ready", 256'(sif.s_ready), 256'(exp_ready));
            check("wr_en",   256'(wr_en),       256'(exp_wr_en));
            check("busy",    256'(busy),        256'(exp_busy));
            check("err",     256'(err),         256'(exp_err));
            check("wr_addr", 256'(wr_addr),     256'(exp_wr_addr));
            check("wr_data", wr_data,           exp_wr_data);
            if (wr_en === 1'b1) begin
                wr_count[wr_addr]++;
                wr_total++;
                wr_cyc_prev = wr_cyc_last;
                wr_cyc_last = cyc;
                last_addr   = wr_addr;
                last_data   = wr_data;
            end
            if (err === 1'b1) err_count++;
        end
    end

    task automatic idle(input int n);
        sif.s_valid = 1'b0;
        repeat (n) begin
            @(posedge vga_clk);
            #2;
        end
    endtask

    task automatic send(input logic [3:0] sel, input logic [15:0] row, input int gap, output int waited);
        bit done;
        if (gap > 0) idle(gap);
        sif.s_valid = 1'b1;
        sif.s_sel   = sel;
        sif.s_row   = row;
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 64) begin
            @(posedge vga_clk);
            #2;
            waited++;
            if (m_acc) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: beat sel %0d not accepted within %0d cycles", sel, waited);
        end
    endtask

    localparam logic [255:0] DIAG = {16'h8000, 16'h4000, 16'h2000, 16'h1000,
                                     16'h0800, 16'h0400, 16'h0200, 16'h0100,
                                     16'h0080, 16'h0040, 16'h0020, 16'h0010,
                                     16'h0008, 16'h0004, 16'h0002, 16'h0001};

    initial begin : stim
        int           w;
        int           base_err, base_w3, base_w4, base_tot;
        logic [3:0]   cur;
        logic [15:0]  top_row;
        sif.s_valid = 1'b0;
        sif.s_sel   = 4'd0;
        sif.s_row   = 16'd0;
        repeat (3) @(posedge vga_clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Diagonal glyph into slot 5.
        for (int r = 0; r < 16; r++) send(4'd5, 16'h8000 >> r, 0, w);
        idle(3);
        check("diag_model_pin", exp_wr_data, DIAG);
        check("diag_count", 256'(wr_count[5]), 256'd1);
        check("diag_addr", 256'(last_addr), 256'd5);
        check("diag_data", last_data, DIAG);
        for (int r = 0; r < 16; r++) check("diag_render", 256'(last_data[255 - 17*r]), 256'd1);

        // Back-to-back glyphs with valid held high.
        for (int r = 0; r < 16; r++) send(4'd1, 16'hFFFF, 0, w);
        for (int r = 0; r < 16; r++) send(4'd2, 16'h0000, 0, w);
        idle(3);
        check("b2b_spacing", 256'(wr_cyc_last - wr_cyc_prev), 256'd17);
        check("b2b_count1", 256'(wr_count[1]), 256'd1);
        check("b2b_data2", last_data, 256'd0);

        // Beat offered during the commit cycle must wait one cycle.
        for (int r = 0; r < 16; r++) send(4'd6, 16'($urandom), 0, w);
        send(4'd7, 16'hA5A5, 0, w);
        check("bp_wait", 256'(w), 256'd2);
        for (int r = 1; r < 16; r++) send(4'd7, 16'($urandom), 0, w);
        idle(3);
        top_row = last_data[255 -: 16];
        check("bp_row0", 256'(top_row), 256'hA5A5);
        check("bp_addr", 256'(last_addr), 256'd7);

        // Slot change mid-glyph discards the partial.
        base_err = err_count;
        base_w3  = wr_count[3];
        base_w4  = wr_count[4];
        for (int r = 0; r < 7; r++)  send(4'd3, 16'($urandom), 0, w);
        for (int r = 0; r < 16; r++) send(4'd4, 16'($urandom), 0, w);
        idle(3);
        check("sel_err_pulses", 256'(err_count - base_err), 256'd1);
        check("sel_no_write3", 256'(wr_count[3] - base_w3), 256'd0);
        check("sel_write4", 256'(wr_count[4] - base_w4), 256'd1);

        // Reset after 10 rows.
        base_tot = wr_total;
        for (int r = 0; r < 10; r++) send(4'd8, 16'($urandom), 0, w);
        sif.s_valid = 1'b0;
        #4;
        rst_n = 1'b0;
        repeat (2) @(posedge vga_clk);
        #2;
        rst_n = 1'b1;
        idle(20);
        check("rst_no_write", 256'(wr_total - base_tot), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        for (int r = 0; r < 16; r++) send(4'd9, 16'($urandom), 0, w);
        idle(3);
        check("rst_fresh_write", 256'(wr_count[9]), 256'd1);

        // Sparse random beats with occasional slot changes.
        cur = 4'($urandom_range(0, 15));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) cur = 4'($urandom_range(0, 15));
            send(cur, 16'($urandom), $urandom_range(0, 3), w);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
